// File: rtl/memory_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single shared memory bus.
// One transaction at a time, with an IDLE cycle between grants and an optional timeout abort.
module memory_bus_arbiter #(
  parameter int ADDRESS_SIZE   = 15,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] m0Address,
  input  logic                    m0Strobe,
  input  logic                    m0WriteEnable,
  input  logic [31:0]             m0DataWrite,
  output logic [31:0]             m0DataRead,
  output logic                    m0Ready,
  output logic                    m0Error,
  input  logic [ADDRESS_SIZE-1:0] m1Address,
  input  logic                    m1Strobe,
  input  logic                    m1WriteEnable,
  input  logic [31:0]             m1DataWrite,
  output logic [31:0]             m1DataRead,
  output logic                    m1Ready,
  output logic                    m1Error,
  output logic [ADDRESS_SIZE-1:0] sAddress,
  output logic                    sStrobe,
  output logic                    sWriteEnable,
  output logic [31:0]             sDataWrite,
  input  logic [31:0]             sDataRead,
  input  logic                    sReady,
  output logic [1:0]              grant
);

  // A zero timeout still needs a one-bit counter to keep widths legal.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic          lastGrant_q, lastGrant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic owner_strobe;
  logic timeout_hit;

  assign owner_strobe = (state_q == GRANT1) ? m1Strobe : m0Strobe;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0Strobe && m1Strobe) begin
          // Tie goes to whoever was not served last.
          state_d     = lastGrant_q ? GRANT0 : GRANT1;
          lastGrant_d = ~lastGrant_q;
        end else if (m0Strobe) begin
          state_d     = GRANT0;
          lastGrant_d = 1'b0;
        end else if (m1Strobe) begin
          state_d     = GRANT1;
          lastGrant_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (!owner_strobe || sReady || timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0DataRead = sDataRead;
  assign m1DataRead = sDataRead;

  always_comb begin
    grant        = state_q;
    sAddress     = '0;
    sStrobe      = 1'b0;
    sWriteEnable = 1'b0;
    sDataWrite   = '0;
    m0Ready      = 1'b0;
    m1Ready      = 1'b0;
    m0Error      = 1'b0;
    m1Error      = 1'b0;
    case (state_q)
      GRANT0: begin
        sAddress     = m0Address;
        sStrobe      = m0Strobe;
        sWriteEnable = m0WriteEnable;
        sDataWrite   = m0DataWrite;
        m0Ready      = sReady && m0Strobe;
        m0Error      = m0Strobe && !sReady && timeout_hit;
      end
      GRANT1: begin
        sAddress     = m1Address;
        sStrobe      = m1Strobe;
        sWriteEnable = m1WriteEnable;
        sDataWrite   = m1DataWrite;
        m1Ready      = sReady && m1Strobe;
        m1Error      = m1Strobe && !sReady && timeout_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: vector table, directed corner sequences and
// random traffic against a transaction-level owner/age model.
module tb_memory_bus_arbiter;
  localparam int AW = 15;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] m0Address, m1Address, sAddress;
  logic          m0Strobe, m1Strobe, m0WriteEnable, m1WriteEnable;
  logic [31:0]   m0DataWrite, m1DataWrite, m0DataRead, m1DataRead;
  logic          m0Ready, m1Ready, m0Error, m1Error;
  logic          sStrobe, sWriteEnable, sReady;
  logic [31:0]   sDataWrite, sDataRead;
  logic [1:0]    grant;

  int checks = 0;
  int errors = 0;

  // Model: who owns the bus (-1 none), how many grant cycles without ready, who was served last.
  int mo_owner, mo_age, mo_last;

  typedef struct {
    logic       s0, s1, rdy;
    logic [1:0] g;
    logic       stb, r0, r1, e0, e1;
  } vec_t;
  vec_t tbl[25];

  memory_bus_arbiter #(.ADDRESS_SIZE(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .m0Address(m0Address), .m0Strobe(m0Strobe), .m0WriteEnable(m0WriteEnable),
    .m0DataWrite(m0DataWrite), .m0DataRead(m0DataRead), .m0Ready(m0Ready), .m0Error(m0Error),
    .m1Address(m1Address), .m1Strobe(m1Strobe), .m1WriteEnable(m1WriteEnable),
    .m1DataWrite(m1DataWrite), .m1DataRead(m1DataRead), .m1Ready(m1Ready), .m1Error(m1Error),
    .sAddress(sAddress), .sStrobe(sStrobe), .sWriteEnable(sWriteEnable),
    .sDataWrite(sDataWrite), .sDataRead(sDataRead), .sReady(sReady), .grant(grant)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mo_owner = -1;
    mo_age   = 0;
    mo_last  = 1;
  endtask

  function automatic logic model_err(input int n);
    logic st;
    st = (n == 0) ? m0Strobe : m1Strobe;
    return (mo_owner == n) && st && !sReady && (TO != 0) && (mo_age == TO);
  endfunction

  task automatic model_check();
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic          es, ew;
    ea = '0; ed = '0; es = 1'b0; ew = 1'b0;
    if (mo_owner == 0) begin
      ea = m0Address; ed = m0DataWrite; es = m0Strobe; ew = m0WriteEnable;
    end else if (mo_owner == 1) begin
      ea = m1Address; ed = m1DataWrite; es = m1Strobe; ew = m1WriteEnable;
    end
    chk("grant", grant, (mo_owner < 0) ? 2'b00 : (mo_owner == 0) ? 2'b01 : 2'b10);
    chk("sStrobe", sStrobe, es);
    chk("sAddress", sAddress, ea);
    chk("sWriteEnable", sWriteEnable, ew);
    chk("sDataWrite", sDataWrite, ed);
    chk("m0Ready", m0Ready, sReady && mo_owner == 0 && m0Strobe);
    chk("m1Ready", m1Ready, sReady && mo_owner == 1 && m1Strobe);
    chk("m0Error", m0Error, model_err(0));
    chk("m1Error", m1Error, model_err(1));
    chk("m0DataRead", m0DataRead, sDataRead);
    chk("m1DataRead", m1DataRead, sDataRead);
  endtask

  task automatic model_update();
    logic st;
    if (mo_owner < 0) begin
      if (m0Strobe && m1Strobe) mo_owner = (mo_last == 0) ? 1 : 0;
      else if (m0Strobe)        mo_owner = 0;
      else if (m1Strobe)        mo_owner = 1;
      if (mo_owner >= 0) begin
        mo_last = mo_owner;
        mo_age  = 0;
      end
    end else begin
      st = (mo_owner == 0) ? m0Strobe : m1Strobe;
      if (!st || sReady || model_err(mo_owner)) begin
        mo_owner = -1;
        mo_age   = 0;
      end else begin
        mo_age++;
      end
    end
  endtask

  // Called at the falling edge: drive, settle, compare against the model.
  task automatic drive_chk(input logic s0, input logic s1, input logic rdy);
    m0Strobe = s0;
    m1Strobe = s1;
    sReady   = rdy;
    #1;
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic step(input logic s0, input logic s1, input logic rdy);
    drive_chk(s0, s1, rdy);
    advance();
  endtask

  initial begin
    // Both requesters contending, one-cycle transactions each.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    // m0 alone, no sReady: error on the fifth grant cycle.
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    // Same again, but sReady lands in the timeout cycle.
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // sReady while idle is ignored; m1 dropping strobe mid-grant aborts silently.
    tbl[20] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    m0Address = AW'(16'h0123); m1Address = AW'(16'h7FFF);
    m0WriteEnable = 1'b0;      m1WriteEnable = 1'b1;
    m0DataWrite = 32'hA5A5_0000; m1DataWrite = 32'h1234_5678;
    sDataRead = 32'hDEAD_BEEF;
    m0Strobe = 1'b1; m1Strobe = 1'b1; sReady = 1'b1;
    model_reset();

    // Reset state with every input trying to provoke an output.
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_sStrobe", sStrobe, 1'b0);
    chk("rst_m0Ready", m0Ready, 1'b0);
    chk("rst_m1Ready", m1Ready, 1'b0);
    chk("rst_errors", {m0Error, m1Error}, 2'b00);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_grant", grant, 2'b00);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive_chk(tbl[i].s0, tbl[i].s1, tbl[i].rdy);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_sStrobe", i), sStrobe, tbl[i].stb);
      chk($sformatf("tbl%0d_ready", i), {m0Ready, m1Ready}, {tbl[i].r0, tbl[i].r1});
      chk($sformatf("tbl%0d_error", i), {m0Error, m1Error}, {tbl[i].e0, tbl[i].e1});
      advance();
    end

    // m0 read of 0x0123, sReady on the third grant cycle.
    step(1'b1, 1'b0, 1'b0);
    drive_chk(1'b1, 1'b0, 1'b0); chk("rd_grant1", grant, 2'b01);
    chk("rd_addr", sAddress, AW'(16'h0123)); chk("rd_we", sWriteEnable, 1'b0); advance();
    drive_chk(1'b1, 1'b0, 1'b0); chk("rd_grant2", grant, 2'b01); advance();
    drive_chk(1'b1, 1'b0, 1'b1); chk("rd_grant3", grant, 2'b01);
    chk("rd_ready", m0Ready, 1'b1); chk("rd_data", m0DataRead, 32'hDEAD_BEEF); advance();
    drive_chk(1'b0, 1'b0, 1'b0); chk("rd_grant4", grant, 2'b00); chk("rd_ready_off", m0Ready, 1'b0); advance();

    // m1 write holds the bus while m0 arrives; m0 is served afterwards.
    step(1'b0, 1'b1, 1'b0);
    drive_chk(1'b0, 1'b1, 1'b0); chk("wr_addr", sAddress, AW'(16'h7FFF));
    chk("wr_data", sDataWrite, 32'h1234_5678); chk("wr_we", sWriteEnable, 1'b1); advance();
    drive_chk(1'b1, 1'b1, 1'b0); chk("wr_hold_grant", grant, 2'b10);
    chk("wr_hold_addr", sAddress, AW'(16'h7FFF)); chk("wr_m0_no_ready", m0Ready, 1'b0); advance();
    drive_chk(1'b1, 1'b1, 1'b1); chk("wr_ready", m1Ready, 1'b1); chk("wr_m0_ready", m0Ready, 1'b0); advance();
    drive_chk(1'b1, 1'b0, 1'b0); chk("wr_gap", sStrobe, 1'b0); advance();
    drive_chk(1'b1, 1'b0, 1'b0); chk("wr_next_m0", grant, 2'b01); chk("wr_next_addr", sAddress, AW'(16'h0123)); advance();
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of an m1 transaction.
    step(1'b0, 1'b1, 1'b0);
    drive_chk(1'b0, 1'b1, 1'b0); chk("mr_grant_pre", grant, 2'b10);
    reset = 1'b0;
    #1;
    chk("mr_sStrobe", sStrobe, 1'b0);
    chk("mr_grant", grant, 2'b00);
    chk("mr_ready_err", {m0Ready, m1Ready, m0Error, m1Error}, 4'b0000);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    drive_chk(1'b1, 1'b1, 1'b0); chk("mr_first_m0", grant, 2'b01); advance();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      m0Address     = AW'($urandom);
      m1Address     = AW'($urandom);
      m0WriteEnable = 1'($urandom);
      m1WriteEnable = 1'($urandom);
      m0DataWrite   = $urandom;
      m1DataWrite   = $urandom;
      sDataRead     = $urandom;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
